// File: rtl/vproc_mem_arbiter.sv
// Round-robin two-requester arbiter onto one memory port, adds ADDR_OFFSET, rejects misaligned accesses; optional watchdog via VPROC_MEM_ARB_TIMEOUT_EN.
// Latency: grant same cycle as request in IDLE, mem_req one cycle later, response one cycle after mem_rvalid_i.
// Backpressure: requesters hold req until gnt; one transaction outstanding, so no grant outside IDLE.
module vproc_mem_arbiter #(
    parameter int unsigned MEM_W          = 32,
    parameter logic [31:0] ADDR_OFFSET    = 32'h0000_2000,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               r0_req_i,
    input  logic [31:0]        r0_addr_i,
    input  logic               r0_we_i,
    input  logic [MEM_W/8-1:0] r0_be_i,
    input  logic [MEM_W-1:0]   r0_wdata_i,
    output logic               r0_gnt_o,
    output logic               r0_rvalid_o,
    output logic               r0_err_o,
    output logic [MEM_W-1:0]   r0_rdata_o,
    input  logic               r1_req_i,
    input  logic [31:0]        r1_addr_i,
    input  logic               r1_we_i,
    input  logic [MEM_W/8-1:0] r1_be_i,
    input  logic [MEM_W-1:0]   r1_wdata_i,
    output logic               r1_gnt_o,
    output logic               r1_rvalid_o,
    output logic               r1_err_o,
    output logic [MEM_W-1:0]   r1_rdata_o,
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    output logic               mem_we_o,
    output logic [MEM_W/8-1:0] mem_be_o,
    output logic [MEM_W-1:0]   mem_wdata_o,
    input  logic               mem_rvalid_i,
    input  logic               mem_err_i,
    input  logic [MEM_W-1:0]   mem_rdata_i,
    output logic               stray_rsp_o
);

    localparam int unsigned BE_W       = MEM_W / 8;
    localparam logic [31:0] ALIGN_MASK = 32'(BE_W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_REJECT = 2'd3;

    if (MEM_W % 8 != 0 || TIMEOUT_CYCLES == 0) begin : g_param_err
        $error("vproc_mem_arbiter: MEM_W must be a byte multiple and TIMEOUT_CYCLES nonzero");
    end

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [BE_W-1:0]  be_q, be_d;
    logic [MEM_W-1:0] wdata_q, wdata_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       err_q, err_d;
    logic [MEM_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic             stray_q, stray_d;

    logic             gnt0, gnt1, timeout_hit;
    logic [31:0]      req_addr;
    logic             rsp_fire, rsp_err;
    logic [MEM_W-1:0] rsp_data;

    // On a tie, the requester that was not granted last wins.
    assign gnt0     = (state_q == S_IDLE) && r0_req_i && (!r1_req_i || last_q);
    assign gnt1     = (state_q == S_IDLE) && r1_req_i && (!r0_req_i || !last_q);
    assign req_addr = gnt1 ? r1_addr_i : r0_addr_i;

`ifdef VPROC_MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ISSUE)
            cnt_d = '0;
        else if (state_q == S_WAIT)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rvalid_d = '0;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        stray_d  = stray_q | (mem_rvalid_i && (state_q != S_WAIT));
        rsp_fire = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    last_d  = gnt1;
                    addr_d  = req_addr + ADDR_OFFSET;
                    we_d    = gnt1 ? r1_we_i    : r0_we_i;
                    be_d    = gnt1 ? r1_be_i    : r0_be_i;
                    wdata_d = gnt1 ? r1_wdata_i : r0_wdata_i;
                    state_d = ((req_addr & ALIGN_MASK) != '0) ? S_REJECT : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A real response beats a watchdog expiry in the same cycle.
                if (mem_rvalid_i) begin
                    rsp_fire = 1'b1;
                    rsp_err  = mem_err_i;
                    rsp_data = mem_rdata_i;
                    state_d  = S_IDLE;
                end else if (timeout_hit) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                rsp_fire = 1'b1;
                rsp_err  = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
        if (rsp_fire) begin
            rvalid_d[owner_q] = 1'b1;
            err_d[owner_q]    = rsp_err;
            if (owner_q) rdata1_d = rsp_data;
            else         rdata0_d = rsp_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            stray_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            stray_q  <= stray_d;
        end
    end

    assign r0_gnt_o    = gnt0;
    assign r1_gnt_o    = gnt1;
    assign r0_rvalid_o = rvalid_q[0];
    assign r1_rvalid_o = rvalid_q[1];
    assign r0_err_o    = err_q[0];
    assign r1_err_o    = err_q[1];
    assign r0_rdata_o  = rdata0_q;
    assign r1_rdata_o  = rdata1_q;
    assign mem_req_o   = (state_q == S_ISSUE);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign stray_rsp_o = stray_q;

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// Randomized bench for vproc_mem_arbiter; the reference model predicts each transaction's timeline
// (grant, issue, response cycles) from the arbitration rules instead of tracking FSM states.
module tb_vproc_mem_arbiter;
    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        r0_req_i = 0, r1_req_i = 0, r0_we_i = 0, r1_we_i = 0;
    logic [31:0] r0_addr_i = 0, r1_addr_i = 0, r0_wdata_i = 0, r1_wdata_i = 0;
    logic [3:0]  r0_be_i = 0, r1_be_i = 0;
    logic        r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o, r0_err_o, r1_err_o;
    logic [31:0] r0_rdata_o, r1_rdata_o;
    logic        mem_req_o, mem_we_o, stray_rsp_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i = 0, mem_err_i = 0;
    logic [31:0] mem_rdata_i = 0;

    always #5 clk_i = ~clk_i;

    vproc_mem_arbiter #(.MEM_W(32), .ADDR_OFFSET(32'h0000_2000), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .r0_req_i(r0_req_i), .r0_addr_i(r0_addr_i), .r0_we_i(r0_we_i), .r0_be_i(r0_be_i),
        .r0_wdata_i(r0_wdata_i), .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o),
        .r0_err_o(r0_err_o), .r0_rdata_o(r0_rdata_o),
        .r1_req_i(r1_req_i), .r1_addr_i(r1_addr_i), .r1_we_i(r1_we_i), .r1_be_i(r1_be_i),
        .r1_wdata_i(r1_wdata_i), .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o),
        .r1_err_o(r1_err_o), .r1_rdata_o(r1_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
        .stray_rsp_o(stray_rsp_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Pending requests and transaction timeline
    int          cyc = 0;
    bit          pend [2];
    logic [31:0] p_addr [2], p_wdata [2];
    logic        p_we [2];
    logic [3:0]  p_be [2];
    int          gap [2];
    int          last_g, own, free_cyc, issue_cyc, rsp_cyc, dlv_cyc, stray_cyc;
    logic [31:0] t_addr, t_wdata, t_rdata, d_rdata;
    logic        t_we, t_err, d_err;
    logic [3:0]  t_be;
    logic [31:0] h_rdata [2];
    logic        h_err [2];
    bit          exp_stray;
    bit          auto_gen = 0, allow_mis = 1, force_dat_en = 0;
    int          gap_max = 0, force_lat = 0;
    logic [31:0] force_dat;
    int          order_q [$];
    bit          seen_req;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;
    logic [3:0]  seen_be;

    task automatic new_req(input int i);
        pend[i]    = 1;
        p_addr[i]  = $urandom & 32'h0000_FFFC;
        if (allow_mis && $urandom_range(0, 3) == 0) p_addr[i] = p_addr[i] | 32'($urandom_range(1, 3));
        p_we[i]    = 1'($urandom);
        p_be[i]    = 4'($urandom);
        p_wdata[i] = $urandom;
    endtask

    task automatic grant(input int g);
        int lat;
        own = g; last_g = g; order_q.push_back(g);
        t_addr = p_addr[g]; t_we = p_we[g]; t_be = p_be[g]; t_wdata = p_wdata[g];
        pend[g] = 0; gap[g] = $urandom_range(0, gap_max);
        if (t_addr[1:0] != 2'b00) begin
            issue_cyc = -1; rsp_cyc = -1; dlv_cyc = cyc + 2;
            d_err = 1'b1; d_rdata = '0;
        end else begin
            issue_cyc = cyc + 1;
            lat = (force_lat != 0) ? force_lat : $urandom_range(1, 3);
            t_rdata = force_dat_en ? force_dat : $urandom;
            t_err = force_dat_en ? 1'b0 : ($urandom_range(0, 3) == 0);
            if (lat < 0) begin
                rsp_cyc = -1; dlv_cyc = issue_cyc + 1 + TO + 1;
                d_err = 1'b1; d_rdata = '0;
            end else begin
                rsp_cyc = issue_cyc + lat; dlv_cyc = rsp_cyc + 1;
                d_err = t_err; d_rdata = t_rdata;
            end
        end
        free_cyc = dlv_cyc;
    endtask

    task automatic run(input int n);
        int eg;
        for (int k = 0; k < n; k++) begin
            r0_req_i = pend[0]; r0_addr_i = p_addr[0]; r0_we_i = p_we[0]; r0_be_i = p_be[0]; r0_wdata_i = p_wdata[0];
            r1_req_i = pend[1]; r1_addr_i = p_addr[1]; r1_we_i = p_we[1]; r1_be_i = p_be[1]; r1_wdata_i = p_wdata[1];
            mem_rvalid_i = (cyc == rsp_cyc) || (cyc == stray_cyc);
            mem_rdata_i  = (cyc == rsp_cyc) ? t_rdata : $urandom;
            mem_err_i    = (cyc == rsp_cyc) ? t_err : 1'($urandom);
            @(negedge clk_i);
            eg = -1;
            if (cyc >= free_cyc) begin
                if (pend[0] && pend[1]) eg = 1 - last_g;
                else if (pend[0])       eg = 0;
                else if (pend[1])       eg = 1;
            end
            chk("gnt0", r0_gnt_o, eg == 0);
            chk("gnt1", r1_gnt_o, eg == 1);
            chk("mem_req", mem_req_o, cyc == issue_cyc);
            if (mem_req_o) begin
                seen_req = 1; seen_addr = mem_addr_o; seen_we = mem_we_o; seen_be = mem_be_o; seen_wdata = mem_wdata_o;
            end
            if (issue_cyc >= 0 && cyc >= issue_cyc && cyc < dlv_cyc) begin
                chk("mem_addr", mem_addr_o, t_addr + 32'h0000_2000);
                chk("mem_we", mem_we_o, t_we);
                chk("mem_be", mem_be_o, t_be);
                chk("mem_wdata", mem_wdata_o, t_wdata);
            end
            if (cyc == dlv_cyc) begin
                h_rdata[own] = d_rdata; h_err[own] = d_err;
            end
            chk("rvalid0", r0_rvalid_o, cyc == dlv_cyc && own == 0);
            chk("rvalid1", r1_rvalid_o, cyc == dlv_cyc && own == 1);
            chk("rdata0", r0_rdata_o, h_rdata[0]);
            chk("err0", r0_err_o, h_err[0]);
            chk("rdata1", r1_rdata_o, h_rdata[1]);
            chk("err1", r1_err_o, h_err[1]);
            chk("stray", stray_rsp_o, exp_stray);
            if (cyc == stray_cyc) exp_stray = 1;
            if (eg >= 0) grant(eg);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && auto_gen) begin
                    if (gap[i] == 0) new_req(i);
                    else gap[i]--;
                end
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        r0_req_i = 0; r1_req_i = 0; mem_rvalid_i = 0;
        rst_ni = 1'b0;
        #2;
        chk("rst_gnt0", r0_gnt_o, 0);        chk("rst_gnt1", r1_gnt_o, 0);
        chk("rst_rvalid0", r0_rvalid_o, 0);  chk("rst_rvalid1", r1_rvalid_o, 0);
        chk("rst_err0", r0_err_o, 0);        chk("rst_err1", r1_err_o, 0);
        chk("rst_rdata0", r0_rdata_o, 0);    chk("rst_rdata1", r1_rdata_o, 0);
        chk("rst_mem_req", mem_req_o, 0);    chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_we", mem_we_o, 0);      chk("rst_mem_be", mem_be_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0); chk("rst_stray", stray_rsp_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        last_g = 1; free_cyc = 0; issue_cyc = -1; rsp_cyc = -1; dlv_cyc = -1; stray_cyc = -1; own = 0;
        exp_stray = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; gap[i] = 0; h_rdata[i] = '0; h_err[i] = 1'b0;
            p_addr[i] = '0; p_we[i] = 0; p_be[i] = '0; p_wdata[i] = '0;
        end
        order_q.delete();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drain();
        auto_gen = 0; force_lat = 0; force_dat_en = 0;
        run(40);
        seen_req = 0;
    endtask

    initial begin
        #1;
        do_reset();

        // Tie from reset: both hold requests, aligned only
        allow_mis = 0; auto_gen = 1; gap_max = 0;
        new_req(0); new_req(1);
        run(14);
        chk("tie_n_grants", order_q.size() >= 4, 1);
        if (order_q.size() >= 4) begin
            chk("tie_g0", order_q[0], 0); chk("tie_g1", order_q[1], 1);
            chk("tie_g2", order_q[2], 0); chk("tie_g3", order_q[3], 1);
        end
        drain();

        // Single read
        pend[0] = 1; p_addr[0] = 32'h100; p_we[0] = 0; p_be[0] = 4'hF; p_wdata[0] = 0;
        force_lat = 2; force_dat_en = 1; force_dat = 32'hDEAD_BEEF;
        run(8);
        chk("rd_req_seen", seen_req, 1);
        chk("rd_addr", seen_addr, 32'h2100);
        chk("rd_rdata", r0_rdata_o, 32'hDEAD_BEEF);
        chk("rd_err", r0_err_o, 0);
        drain();

        // Write from r1
        pend[1] = 1; p_addr[1] = 32'h40; p_we[1] = 1; p_be[1] = 4'b0011; p_wdata[1] = 32'h1234_5678;
        force_lat = 1;
        run(8);
        chk("wr_addr", seen_addr, 32'h2040);
        chk("wr_we", seen_we, 1);
        chk("wr_be", seen_be, 4'b0011);
        chk("wr_wdata", seen_wdata, 32'h1234_5678);
        drain();

        // Misaligned read
        pend[0] = 1; p_addr[0] = 32'h102; p_we[0] = 0; p_be[0] = 4'hF;
        run(6);
        chk("mis_no_req", seen_req, 0);
        chk("mis_err", r0_err_o, 1);
        chk("mis_rdata", r0_rdata_o, 0);
        drain();

        // Random traffic with both requesters
        allow_mis = 1; auto_gen = 1; gap_max = 3;
        run(2000);
        drain();

`ifdef VPROC_MEM_ARB_TIMEOUT_EN
        pend[0] = 1; p_addr[0] = 32'h200; p_we[0] = 0; p_be[0] = 4'hF;
        force_lat = -1;
        run(12);
        chk("to_err", r0_err_o, 1);
        chk("to_rdata", r0_rdata_o, 0);
        drain();
`endif

        // Response arriving while idle
        stray_cyc = cyc + 2;
        run(5);
        chk("stray_set", stray_rsp_o, 1);
        run(3);
        chk("stray_sticky", stray_rsp_o, 1);

        // Reset while waiting on memory, then a tie
        pend[1] = 1; p_addr[1] = 32'h80; p_we[1] = 0; p_be[1] = 4'hF;
        force_lat = 10;
        run(4);
        do_reset();
        force_lat = 0; allow_mis = 0; auto_gen = 1; gap_max = 0;
        new_req(0); new_req(1);
        run(8);
        chk("rst_tie_n", order_q.size() >= 2, 1);
        if (order_q.size() >= 2) begin
            chk("rst_tie_first", order_q[0], 0);
            chk("rst_tie_second", order_q[1], 1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
